// File: rtl/ebus_pkg.sv
// ebus_pkg: shared EBUS controller states, function codes and bus widths
package ebus_pkg;
    localparam int EBUS_DS_WIDTH = 8;
    typedef enum logic [2:0] {IDLE, GRANT, SETUP, STROBE, DEMAND, WAITREL} ebusState_e;
    typedef enum logic [2:0] {CONO = 3'b000, DATAO = 3'b001, CONI = 3'b110, DATAI = 3'b111} ebusFunc_e;
    function automatic logic [2:0] funcCode(input logic f01, input logic f02);
        return {f01, f01, f02};
    endfunction
endpackage

// File: rtl/ebus_if.sv
// ebus_if: EBUS handshake between the PI-side controller and the requester/device side
interface ebus_if;
    import ebus_pkg::*;
    logic ebusReq, ebusDemand, ebusReturn, ebusF01, sendF02, ebusXfer;
    logic [EBUS_DS_WIDTH-1:0] devSel, EBUS_DS;
    logic [2:0] EBUS_FUNC;
    logic ebusGrant, ebusDSStrobe, ebusDemandOut, ebusXferDone, ebusTimeout, ebusBusy;
    modport master (
        output ebusReq, ebusDemand, ebusReturn, ebusF01, sendF02, devSel, ebusXfer,
        input ebusGrant, EBUS_DS, ebusDSStrobe, EBUS_FUNC, ebusDemandOut, ebusXferDone, ebusTimeout, ebusBusy
    );
    modport slave (
        input ebusReq, ebusDemand, ebusReturn, ebusF01, sendF02, devSel, ebusXfer,
        output ebusGrant, EBUS_DS, ebusDSStrobe, EBUS_FUNC, ebusDemandOut, ebusXferDone, ebusTimeout, ebusBusy
    );
endinterface

// File: rtl/ebus_timer.sv
// ebus_timer: loadable down-counter that saturates at zero
module ebus_timer #(
    parameter int WIDTH = 7
) (
    input logic clk,
    input logic rst,
    input logic load,
    input logic [WIDTH-1:0] loadVal,
    input logic en,
    output logic zero
);
    logic [WIDTH-1:0] count;
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (load) count <= loadVal;
        else if (en && count != '0) count <= count - 1'b1;
    assign zero = count == '0;
endmodule

// File: rtl/ebus_ctl.sv
// ebus_ctl: grants EBUS to one requester and sequences select, strobe, demand and release
module ebus_ctl
    import ebus_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int DS_SETUP = 2
) (
    input logic clk,
    input logic CROBAR,
    ebus_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    ebusState_e state, nextState;
    logic timerZero, timerLoad, timerEn, latchSel, xferDoneReg, timeoutReg;
    logic [TW-1:0] timerVal;
    logic [EBUS_DS_WIDTH-1:0] dsReg;
    logic [2:0] funcReg;
    always_ff @(posedge clk or posedge CROBAR)
        if (CROBAR) state <= IDLE;
        else state <= nextState;
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (bus.ebusReq) nextState = GRANT;
            GRANT: nextState = bus.ebusDemand ? SETUP : bus.ebusReturn ? IDLE : GRANT;
            SETUP: if (timerZero) nextState = STROBE;
            STROBE: nextState = DEMAND;
            DEMAND: if (bus.ebusXfer || timerZero) nextState = WAITREL;
            WAITREL: if (!bus.ebusDemand) nextState = bus.ebusReturn ? IDLE : GRANT;
            default: nextState = IDLE;
        endcase
    end
    // one timer serves both waits: setup length on demand accept, timeout window on strobe
    always_comb begin
        latchSel = (state == IDLE && bus.ebusReq) || (state == GRANT && bus.ebusDemand);
        timerLoad = (state == GRANT && bus.ebusDemand) || state == STROBE;
        timerVal = state == STROBE ? TW'(TIMEOUT_CYC - 1) : TW'(DS_SETUP - 1);
        timerEn = state == SETUP || state == DEMAND;
    end
    ebus_timer #(.WIDTH(TW)) timer (
        .clk(clk),
        .rst(CROBAR),
        .load(timerLoad),
        .loadVal(timerVal),
        .en(timerEn),
        .zero(timerZero)
    );
    // xfer takes priority over an expiry landing in the same cycle
    always_ff @(posedge clk or posedge CROBAR)
        if (CROBAR) begin
            dsReg <= '0;
            funcReg <= '0;
            xferDoneReg <= 1'b0;
            timeoutReg <= 1'b0;
        end else begin
            if (latchSel) begin
                dsReg <= bus.devSel;
                funcReg <= funcCode(bus.ebusF01, bus.sendF02);
            end
            xferDoneReg <= state == DEMAND && bus.ebusXfer;
            timeoutReg <= state == DEMAND && timerZero && !bus.ebusXfer;
        end
    always_comb begin
        bus.ebusBusy = state != IDLE;
        bus.ebusGrant = state != IDLE;
        bus.ebusDSStrobe = state == STROBE;
        bus.ebusDemandOut = state == DEMAND;
        bus.EBUS_DS = dsReg;
        bus.EBUS_FUNC = funcReg;
        bus.ebusXferDone = xferDoneReg;
        bus.ebusTimeout = timeoutReg;
    end
endmodule

// File: tb/tb_ebus_ctl.sv
// tb_ebus_ctl: directed EBUS scenarios checked every cycle against a transaction-level model
module tb_ebus_ctl;
    import ebus_pkg::*;
    localparam int TIMEOUT_CYC = 64;
    localparam int DS_SETUP = 2;
    logic clk = 1'b0;
    logic CROBAR = 1'b0;
    int errors = 0, checks = 0, cyc = 0;
    ebus_if bus();
    ebus_ctl #(.TIMEOUT_CYC(TIMEOUT_CYC), .DS_SETUP(DS_SETUP)) dut (.clk(clk), .CROBAR(CROBAR), .bus(bus));
    always #5 clk = ~clk;

    // model: ownership flag plus cycles elapsed since the demand was accepted
    bit mGrant = 0, mDone = 0, mXferDone = 0, mTimeout = 0;
    int mSince = -1;
    logic [7:0] mDS = '0;
    logic [2:0] mFunc = '0;
    int nDone = 0, nTimeout = 0, nStrobe = 0, busyLow = 0, demandRiseCyc = 0, timeoutCyc = 0;
    logic [7:0] dsAtStrobe = '0;
    logic [2:0] funcAtStrobe = '0;
    bit prevDem = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge CROBAR);
        if (CROBAR) begin
            mGrant = 0; mDone = 0; mSince = -1; mDS = '0; mFunc = '0; mXferDone = 0; mTimeout = 0;
        end else begin
            cyc++;
            mXferDone = 0;
            mTimeout = 0;
            if (!mGrant) begin
                if (bus.ebusReq) begin
                    mGrant = 1; mDS = bus.devSel; mFunc = {bus.ebusF01, bus.ebusF01, bus.sendF02};
                end
            end else if (mSince < 0) begin
                if (bus.ebusDemand) begin
                    mSince = 0; mDS = bus.devSel; mFunc = {bus.ebusF01, bus.ebusF01, bus.sendF02};
                end else if (bus.ebusReturn) mGrant = 0;
            end else if (!mDone) begin
                if (mSince > DS_SETUP && bus.ebusXfer) begin
                    mDone = 1; mXferDone = 1;
                end else if (mSince - DS_SETUP - 1 == TIMEOUT_CYC - 1) begin
                    mDone = 1; mTimeout = 1;
                end else mSince++;
            end else if (!bus.ebusDemand) begin
                mDone = 0; mSince = -1;
                if (bus.ebusReturn) mGrant = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("grant", bus.ebusGrant, mGrant);
        chk("busy", bus.ebusBusy, mGrant);
        chk("ds", bus.EBUS_DS, mDS);
        chk("func", bus.EBUS_FUNC, mFunc);
        chk("strobe", bus.ebusDSStrobe, mGrant && !mDone && mSince == DS_SETUP);
        chk("demandOut", bus.ebusDemandOut, mGrant && !mDone && mSince > DS_SETUP);
        chk("xferDone", bus.ebusXferDone, mXferDone);
        chk("timeout", bus.ebusTimeout, mTimeout);
        if (bus.ebusXferDone) nDone++;
        if (bus.ebusTimeout) begin nTimeout++; timeoutCyc = cyc; end
        if (bus.ebusDSStrobe) begin nStrobe++; dsAtStrobe = bus.EBUS_DS; funcAtStrobe = bus.EBUS_FUNC; end
        if (!bus.ebusBusy) busyLow++;
        if (bus.ebusDemandOut && !prevDem) demandRiseCyc = cyc;
        prevDem = bus.ebusDemandOut;
    end

    task automatic setIn(input logic req, dem, ret, f01, f02, input logic [7:0] ds, input logic xfer);
        @(negedge clk);
        bus.ebusReq = req; bus.ebusDemand = dem; bus.ebusReturn = ret;
        bus.ebusF01 = f01; bus.sendF02 = f02; bus.devSel = ds; bus.ebusXfer = xfer;
    endtask

    task automatic waitDemand();
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.ebusDemandOut && n < 100);
        chk("demand_reached", bus.ebusDemandOut, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s, t, st, b, d0;
        bus.ebusReq = 0; bus.ebusDemand = 0; bus.ebusReturn = 0; bus.ebusF01 = 0;
        bus.sendF02 = 0; bus.devSel = '0; bus.ebusXfer = 0;
        #1 CROBAR = 1'b1;
        repeat (2) @(negedge clk);
        CROBAR = 1'b0;
        chk("reset_grant", bus.ebusGrant, 0);
        chk("reset_busy", bus.ebusBusy, 0);
        chk("reset_ds", bus.EBUS_DS, 0);
        // CONO: xfer in the third demand cycle
        s = nDone;
        setIn(1, 0, 0, 0, 0, 8'h04, 0);
        chk("cono_grant_before", bus.ebusGrant, 0);
        setIn(0, 1, 0, 0, 0, 8'h04, 0);
        chk("cono_grant_next", bus.ebusGrant, 1);
        waitDemand();
        d0 = cyc;
        setIn(0, 1, 0, 0, 0, 8'h04, 0);
        setIn(0, 1, 0, 0, 0, 8'h04, 1);
        setIn(0, 0, 1, 0, 0, 8'h04, 0);
        chk("cono_done_pulse", bus.ebusXferDone, 1);
        chk("cono_done_delay", cyc - d0, 3);
        setIn(0, 0, 0, 0, 0, 8'h04, 0);
        chk("cono_released", bus.ebusBusy, 0);
        chk("cono_done_count", nDone - s, 1);
        chk("cono_ds_at_strobe", dsAtStrobe, 8'h04);
        chk("cono_func_at_strobe", funcAtStrobe, CONO);
        // DATAI: devSel changes between request and demand, grant held in WAITREL
        setIn(1, 0, 0, 1, 1, 8'h7B, 0);
        setIn(0, 1, 0, 1, 1, 8'h7C, 0);
        waitDemand();
        setIn(0, 1, 0, 1, 1, 8'h7C, 1);
        setIn(0, 1, 0, 1, 1, 8'h7C, 0);
        chk("datai_demand_drop", bus.ebusDemandOut, 0);
        chk("datai_func", bus.EBUS_FUNC, DATAI);
        for (int i = 0; i < 3; i++) begin
            setIn(0, 1, 0, 1, 1, 8'h7C, 0);
            chk("datai_grant_held", bus.ebusGrant, 1);
        end
        setIn(0, 0, 1, 1, 1, 8'h7C, 0);
        setIn(0, 0, 0, 1, 1, 8'h7C, 0);
        chk("datai_ds_at_strobe", dsAtStrobe, 8'h7C);
        chk("datai_func_at_strobe", funcAtStrobe, DATAI);
        // timeout with no xfer at all
        s = nDone; t = nTimeout;
        setIn(1, 0, 0, 0, 1, 8'h22, 0);
        setIn(0, 1, 0, 0, 1, 8'h22, 0);
        waitDemand();
        repeat (TIMEOUT_CYC + 1) setIn(0, 1, 0, 0, 1, 8'h22, 0);
        chk("to_delay", timeoutCyc - demandRiseCyc, 64);
        chk("to_count", nTimeout - t, 1);
        chk("to_no_done", nDone - s, 0);
        setIn(0, 0, 1, 0, 1, 8'h22, 0);
        setIn(0, 0, 0, 0, 1, 8'h22, 0);
        // xfer lands exactly on the expiry cycle
        t = nTimeout;
        setIn(1, 0, 0, 1, 0, 8'h31, 0);
        setIn(0, 1, 0, 1, 0, 8'h31, 0);
        waitDemand();
        repeat (62) setIn(0, 1, 0, 1, 0, 8'h31, 0);
        setIn(0, 1, 0, 1, 0, 8'h31, 1);
        setIn(0, 1, 0, 1, 0, 8'h31, 0);
        chk("sim_done", bus.ebusXferDone, 1);
        chk("sim_no_timeout", bus.ebusTimeout, 0);
        setIn(0, 0, 1, 1, 0, 8'h31, 0);
        setIn(0, 0, 0, 1, 0, 8'h31, 0);
        chk("sim_timeout_count", nTimeout - t, 0);
        chk("sim_func_at_strobe", funcAtStrobe, CONI);
        // back-to-back transfers without re-arbitration
        s = nDone; st = nStrobe;
        setIn(1, 0, 0, 0, 1, 8'h55, 0);
        setIn(0, 1, 0, 0, 1, 8'h55, 0);
        waitDemand();
        b = busyLow;
        setIn(0, 1, 0, 0, 1, 8'h55, 1);
        setIn(0, 0, 0, 0, 1, 8'h55, 0);
        setIn(0, 1, 0, 0, 1, 8'h10, 0);
        waitDemand();
        setIn(0, 1, 0, 0, 1, 8'h10, 1);
        setIn(0, 0, 1, 0, 1, 8'h10, 0);
        chk("b2b_no_idle", busyLow - b, 0);
        setIn(0, 0, 0, 0, 1, 8'h10, 0);
        chk("b2b_strobes", nStrobe - st, 2);
        chk("b2b_dones", nDone - s, 2);
        chk("b2b_ds_at_strobe", dsAtStrobe, 8'h10);
        // asynchronous reset in the middle of DEMAND
        setIn(1, 0, 0, 0, 0, 8'h66, 0);
        setIn(0, 1, 0, 0, 0, 8'h66, 0);
        waitDemand();
        #3 CROBAR = 1'b1;
        #1;
        chk("rst_grant", bus.ebusGrant, 0);
        chk("rst_demandOut", bus.ebusDemandOut, 0);
        chk("rst_busy", bus.ebusBusy, 0);
        chk("rst_ds", bus.EBUS_DS, 0);
        chk("rst_func", bus.EBUS_FUNC, 0);
        setIn(0, 0, 0, 0, 0, 8'h00, 0);
        @(negedge clk);
        CROBAR = 1'b0;
        bus.ebusReq = 1; bus.devSel = 8'h09;
        setIn(0, 0, 0, 0, 0, 8'h09, 0);
        chk("rst_regrant", bus.ebusGrant, 1);
        chk("rst_regrant_ds", bus.EBUS_DS, 8'h09);
        setIn(0, 0, 1, 0, 0, 8'h09, 0);
        setIn(0, 0, 0, 0, 0, 8'h09, 0);
        chk("rst_final_idle", bus.ebusBusy, 0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
